// File: rtl/vector_mem_sequencer_if.sv
// Pipeline/RAM bundle for the vector memory sequencer: MEM-stage request,
// RAM access bus and write-back results.
interface vector_mem_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int LANES  = 16
);
  logic                      start_load;
  logic                      start_store;
  logic [ADDR_W-1:0]         base_addr;
  logic [4:0]                rd_in;
  logic [LANES*DATA_W-1:0]   store_data;
  logic [DATA_W-1:0]         mem_q;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_wren;
  logic                      stall;
  logic                      load_valid;
  logic [4:0]                load_rd;
  logic [LANES*DATA_W-1:0]   load_data;

  modport master (
    output start_load, start_store, base_addr, rd_in, store_data, mem_q,
    input  mem_addr, mem_wdata, mem_wren, stall, load_valid, load_rd, load_data
  );

  modport slave (
    input  start_load, start_store, base_addr, rd_in, store_data, mem_q,
    output mem_addr, mem_wdata, mem_wren, stall, load_valid, load_rd, load_data
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// MEM-stage sequencer: splits one vector load/store into LANES scalar RAM
// accesses, stalling the pipeline and assembling loaded lanes for write-back.
module vector_mem_sequencer #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int LANES  = 16
) (
  input logic                  clk,
  input logic                  rst,
  vector_mem_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TAIL,
    S_STORE,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [4:0]               rd_q, rd_d;
  logic [LANES*DATA_W-1:0]  snap_q, snap_d;
  logic [LANES*DATA_W-1:0]  buf_q;
  logic                     is_load_q, is_load_d;
  logic                     cap_en;
  logic [IDX_W-1:0]         cap_lane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      rd_q      <= '0;
      snap_q    <= '0;
      buf_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      rd_q      <= rd_d;
      snap_q    <= snap_d;
      is_load_q <= is_load_d;
      if (cap_en) buf_q[DATA_W*int'(cap_lane) +: DATA_W] <= bus.mem_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    rd_d           = rd_q;
    snap_d         = snap_q;
    is_load_d      = is_load_q;
    cap_en         = 1'b0;
    // RAM read data lags its address by one cycle, so lane idx-1 lands now;
    // idx has wrapped to 0 in TAIL, which makes this lane LANES-1 there.
    cap_lane       = idx_q - IDX_W'(1);
    bus.stall      = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wren   = 1'b0;
    bus.load_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_load || bus.start_store) begin
          bus.stall = rst;
          base_d    = bus.base_addr;
          rd_d      = bus.rd_in;
          snap_d    = bus.store_data;
          idx_d     = '0;
          is_load_d = bus.start_load;
          state_d   = bus.start_load ? S_LOAD : S_STORE;
        end
      end
      S_LOAD: begin
        bus.stall    = 1'b1;
        bus.mem_addr = base_q + ADDR_W'(idx_q);
        cap_en       = (idx_q != '0);
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LANES - 1)) state_d = S_TAIL;
      end
      S_TAIL: begin
        bus.stall = 1'b1;
        cap_en    = 1'b1;
        state_d   = S_DONE;
      end
      S_STORE: begin
        bus.stall     = 1'b1;
        bus.mem_addr  = base_q + ADDR_W'(idx_q);
        bus.mem_wdata = snap_q[DATA_W*int'(idx_q) +: DATA_W];
        bus.mem_wren  = 1'b1;
        idx_d         = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LANES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bus.load_valid = is_load_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.load_rd   = rd_q;
  assign bus.load_data = buf_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: table of directed operations,
// hand-written reset sequences and randomized operations against a RAM model.
module tb_vector_mem_sequencer;
  localparam int AW    = 19;
  localparam int DW    = 16;
  localparam int NL    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  vector_mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .LANES(NL)) vif ();

  vector_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LANES(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  logic [15:0] ram    [0:DEPTH-1];
  logic [15:0] shadow [0:DEPTH-1];

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_word(input int i);
    if (i >= 32'h100 && i < 32'h110) return 16'h1000 + 16'(i - 32'h100);
    return 16'(i * 7) ^ 16'h5A5A;
  endfunction

  // RAM model: synchronous write, registered read (data valid one clock later)
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
    vif.mem_q = '0;
    forever begin
      @(posedge clk);
      if (vif.mem_wren === 1'b1) ram[vif.mem_addr] <= vif.mem_wdata;
      vif.mem_q <= ram[vif.mem_addr];
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] make_vec(input logic [15:0] seed);
    logic [255:0] v;
    for (int k = 0; k < NL; k++) v[16*k +: 16] = seed + 16'(k);
    return v;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_ram(input string name, input logic [18:0] base);
    int mism = 0;
    for (int k = 0; k < NL + 4; k++) begin
      logic [18:0] a;
      a = base + 19'(k);
      if (ram[a] !== shadow[a]) mism++;
    end
    check(name, 256'(mism), 256'(0));
  endtask

  // Reference: a load stalls 18 cycles, a store 17; accesses occupy cycles
  // 1..16 at base+lane (mod 2^19); load wins when both starts are high.
  task automatic run_op(input bit ld, input bit st, input logic [18:0] base,
                        input logic [4:0] rd, input logic [255:0] data, input bit chg,
                        output int stall_cnt, output int wr_cnt);
    int n;
    logic [255:0] exp_vec;
    n = ld ? 18 : 17;
    for (int k = 0; k < NL; k++) exp_vec[16*k +: 16] = shadow[base + 19'(k)];
    vif.start_load  = ld;
    vif.start_store = st;
    vif.base_addr   = base;
    vif.rd_in       = rd;
    vif.store_data  = data;
    stall_cnt = 0;
    wr_cnt    = 0;
    for (int c = 0; c <= n + 1; c++) begin
      logic        e_act, e_wren, e_lv, e_stall;
      logic [18:0] e_addr;
      logic [15:0] e_wdata;
      int          lane;
      @(negedge clk);
      lane    = (c >= 1) ? c - 1 : 0;
      e_act   = (c >= 1 && c <= 16);
      e_stall = (c < n);
      e_addr  = e_act ? base + 19'(lane) : 19'd0;
      e_wren  = e_act && !ld;
      e_wdata = e_wren ? data[16*lane +: 16] : 16'd0;
      e_lv    = (c == n) && ld;
      check($sformatf("cycle%0d", c),
            256'({vif.stall, vif.mem_wren, vif.mem_addr, vif.mem_wdata, vif.load_valid}),
            256'({e_stall, e_wren, e_addr, e_wdata, e_lv}));
      if (vif.stall === 1'b1) stall_cnt++;
      if (vif.mem_wren === 1'b1) wr_cnt++;
      if (c == n && ld) begin
        check("load_data", vif.load_data, exp_vec);
        check("load_rd", 256'(vif.load_rd), 256'(rd));
      end
      @(posedge clk);
      #1;
      if (c == 2 && chg) vif.store_data = '0;
      if (c == n) begin
        vif.start_load  = 1'b0;
        vif.start_store = 1'b0;
        vif.base_addr   = 19'($urandom);
        vif.store_data  = rand_vec();
      end
    end
    if (!ld)
      for (int k = 0; k < NL; k++) shadow[base + 19'(k)] = data[16*k +: 16];
    check_ram("ram", base);
  endtask

  typedef struct {
    bit          ld;
    bit          st;
    logic [18:0] base;
    logic [4:0]  rd;
    logic [15:0] seed;
    bit          chg;
    int          exp_stall;
    int          exp_wr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int sc, wc;
    logic [18:0] rb;

    tbl[0] = '{1, 0, 19'h00100, 5'd5,  16'h0000, 0, 18, 0};
    tbl[1] = '{0, 1, 19'h00200, 5'd0,  16'hA000, 1, 17, 16};
    tbl[2] = '{1, 0, 19'h7FFF8, 5'd12, 16'h0000, 0, 18, 0};
    tbl[3] = '{1, 1, 19'h00300, 5'd9,  16'hC000, 0, 18, 0};
    tbl[4] = '{0, 1, 19'h7FFFC, 5'd0,  16'hD000, 0, 17, 16};
    tbl[5] = '{1, 0, 19'h7FFFC, 5'd31, 16'h0000, 0, 18, 0};

    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);

    vif.start_load  = 1'b0;
    vif.start_store = 1'b0;
    vif.base_addr   = '0;
    vif.rd_in       = '0;
    vif.store_data  = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vif.start_load  = 1'($urandom);
      vif.start_store = 1'($urandom);
      vif.base_addr   = 19'($urandom);
      vif.rd_in       = 5'($urandom);
      vif.store_data  = rand_vec();
      @(negedge clk);
      check("rst_outputs",
            256'({vif.stall, vif.mem_wren, vif.mem_addr, vif.mem_wdata, vif.load_valid, vif.load_rd}),
            256'(0));
      check("rst_load_data", vif.load_data, 256'(0));
    end
    @(posedge clk);
    #1;
    vif.start_load  = 1'b0;
    vif.start_store = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_stall", 256'({vif.stall, vif.mem_wren}), 256'(0));
    end
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].ld, tbl[i].st, tbl[i].base, tbl[i].rd, make_vec(tbl[i].seed),
             tbl[i].chg, sc, wc);
      check($sformatf("tbl%0d_stall", i), 256'(sc), 256'(tbl[i].exp_stall));
      check($sformatf("tbl%0d_writes", i), 256'(wc), 256'(tbl[i].exp_wr));
    end

    // Reset in cycle 8 of a store: only base..base+6 reach the RAM
    vif.start_store = 1'b1;
    vif.base_addr   = 19'h00400;
    vif.store_data  = make_vec(16'hB000);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    vif.start_store = 1'b0;
    #1;
    check("midrst_outputs",
          256'({vif.stall, vif.mem_wren, vif.mem_addr, vif.mem_wdata, vif.load_valid}),
          256'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle", 256'({vif.stall, vif.mem_wren, vif.load_valid}), 256'(0));
    for (int k = 0; k < 7; k++) shadow[19'h00400 + 19'(k)] = 16'hB000 + 16'(k);
    check_ram("midrst_ram", 19'h00400);
    @(posedge clk);
    #1;
    run_op(1'b1, 1'b0, 19'h00400, 5'd3, '0, 1'b0, sc, wc);
    check("midrst_reload_stall", 256'(sc), 256'(18));

    for (int i = 0; i < 12; i++) begin
      bit ld, st, chg;
      ld  = 1'($urandom);
      st  = ld ? 1'($urandom) : 1'b1;
      chg = 1'($urandom);
      rb  = 19'($urandom);
      run_op(ld, st, rb, 5'($urandom), rand_vec(), chg, sc, wc);
      check($sformatf("rand%0d_stall", i), 256'(sc), 256'(ld ? 18 : 17));
      check($sformatf("rand%0d_writes", i), 256'(wc), 256'(ld ? 0 : 16));
      if (!ld) begin
        run_op(1'b1, 1'b0, rb, 5'($urandom), '0, 1'b0, sc, wc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

MEM-stage sequencer that turns one vector load or vector store into 16 consecutive 16-bit accesses on the scalar-width data RAM. It sits between the EX/MEM segment register and the RAM/MEM/WB segment. It freezes the pipeline through `stall` while it works and hands a fully assembled 16×16 vector plus its destination register to write-back.

## Interface
Parameters:
- `ADDR_W`, 19: RAM address width; matches the scalar ALU result width.
- `DATA_W`, 16: RAM word width and vector lane width.
- `LANES`, 16: elements per vector.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: pipeline clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start_load`, in, 1: MEM-stage instruction is a vector load. Held until `stall` drops.
- `start_store`, in, 1: MEM-stage instruction is a vector store. Held until `stall` drops.
- `base_addr`, in, ADDR_W: element-0 address (scalar ALU result).
- `rd_in`, in, 5: destination vector register of the load.
- `store_data`, in, LANES×DATA_W: vector to store. Lane i is bits [16i+15:16i].
- `mem_q`, in, DATA_W: RAM read data. Valid one `clk` after its address is presented.
- `mem_addr`, out, ADDR_W: RAM address.
- `mem_wdata`, out, DATA_W: RAM write data.
- `mem_wren`, out, 1: RAM write enable.
- `stall`, out, 1: freeze IF..EX/MEM.
- `load_valid`, out, 1: one-cycle pulse; assembled vector is available.
- `load_rd`, out, 5: destination register paired with `load_valid`.
- `load_data`, out, LANES×DATA_W: assembled vector.

## Operation
States:
- **IDLE**
  - `start_load` moves to LOAD.
  - `start_store` moves to STORE.
  - If both are high, load wins and nothing is written.
  - On acceptance, latch `base_addr` and `rd_in`; snapshot all of `store_data`; clear the 4-bit index `idx`.
- **LOAD**
  - `mem_addr` = base + idx; `idx` increments every cycle.
  - The word returned for index k is written to lane k of the load buffer on the following edge.
  - After idx = 15 is issued, move to TAIL.
- **TAIL**
  - One cycle.
  - Capture lane 15, then move to DONE.
- **STORE**
  - `mem_addr` = base + idx, `mem_wdata` = snapshot lane idx, `mem_wren` = 1.
  - After idx = 15, move to DONE.
- **DONE**
  - One cycle.
  - `stall` = 0.
  - `load_valid` = 1 only if the operation was a load.
  - Always returns to IDLE.
  - Start inputs are ignored here; they still belong to the completing instruction.

Address arithmetic: base + idx is computed modulo 2^ADDR_W, so 0x7FFFF + 1 wraps to 0x00000.

`stall` = (IDLE and (`start_load` or `start_store`)) or state ∈ {LOAD, TAIL, STORE}. This is combinational from the starts, so the pipeline freezes in the acceptance cycle.

Outside LOAD/STORE: `mem_addr` = 0, `mem_wdata` = 0, `mem_wren` = 0.

`load_data` is the load buffer itself:
- Lanes update during capture.
- Content is defined only while `load_valid` = 1.
- It then holds until the next load's first capture.
- `load_rd` holds the latched `rd_in`.

## Timing
- Reset (asynchronous, `rst` = 0): state = IDLE, `idx` = 0, and every output = 0 (`load_data` all zero, `load_rd` = 0, `stall` = 0 when no start, `mem_wren` = 0).
- Reset mid-operation:
  - `mem_wren` drops immediately.
  - No `load_valid` is produced.
  - Partially written RAM contents are not rolled back.
- Load, with cycle 0 = IDLE and start seen:
  - Cycles 1–16: LOAD, addresses base..base+15.
  - Cycle 17: TAIL.
  - Cycle 18: DONE with `load_valid` = 1.
  - `stall` is high in cycles 0–17 (18 cycles).
- Store, with cycle 0 = acceptance:
  - Cycles 1–16: write lanes 0..15 to base..base+15.
  - Cycle 17: DONE.
  - `stall` is high in cycles 0–16 (17 cycles).
- `store_data` changes after acceptance have no effect.
- Back-to-back operations: a new start is accepted no earlier than the IDLE cycle after DONE.

## Test plan
- **Reset values:** assert `rst` = 0 with random inputs → all outputs 0; release with no start → `stall` stays 0.
- **Vector load:**
  - Stimulus: RAM model holds word 0x1000+k at address 0x00100+k; pulse `start_load`, `base_addr` = 0x00100, `rd_in` = 5.
  - Required: `stall` high exactly 18 cycles; `load_valid` high for one cycle at cycle 18; `load_rd` = 5; lane k = 0x1000+k; `mem_wren` never 1.
- **Vector store:**
  - Stimulus: `store_data` lane k = 0xA000+k, `base_addr` = 0x00200; change `store_data` to 0 at cycle 2.
  - Required: 16 writes, 0xA000+k to 0x00200+k, in cycles 1–16; `load_valid` never 1; `stall` high 17 cycles.
- **Address wrap:** load with `base_addr` = 0x7FFF8 → address sequence 0x7FFF8..0x7FFFF, then 0x00000..0x00007.
- **Simultaneous starts:** `start_load` = `start_store` = 1 → load sequence only; `mem_wren` stays 0.
- **Reset mid-store:**
  - Stimulus: assert `rst` = 0 at cycle 8 of a store.
  - Required: `mem_wren` = 0 in the same cycle; state IDLE; only addresses base..base+6 written; after release, a new load completes normally.
